// File: rtl/bitwise_logic_unit.sv
// bitwise_logic_unit: multi-mode two-operand bitwise function over WIDTH bits,
// computed CHUNK bits per clock behind valid/ready handshakes on both sides.
// A zero flag is produced for branch evaluation.
// Optional feature macro: BLU_POPCOUNT_EN adds a popcnt output holding the
// number of 1 bits in the result, accumulated chunk by chunk.
module bitwise_logic_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             busy
`ifdef BLU_POPCOUNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] popcnt
`endif
);

  localparam int NUM_CHUNKS = WIDTH / CHUNK;
  localparam int CW         = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NUM_CHUNKS - 1);

  // A partial last chunk cannot be expressed, so refuse to build.
  generate
    if ((WIDTH % CHUNK) != 0) begin : g_cfg_err
      $error("bitwise_logic_unit: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] x_r;
  logic [WIDTH-1:0] y_r;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] res_r;
  logic [WIDTH-1:0] res_next_s;
  logic             zero_r;
  logic [CHUNK-1:0] chunk_s;
  logic             accept_s;
  logic             last_s;
  logic             release_s;

  // Selected bitwise function applied to one chunk of the latched operands.
  function automatic logic [CHUNK-1:0] bit_fn(input logic [2:0] f,
                                              input logic [CHUNK-1:0] a,
                                              input logic [CHUNK-1:0] b);
    logic [CHUNK-1:0] r;
    case (f)
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      3'b010:  r = a ^ b;
      3'b011:  r = ~(a | b);
      3'b100:  r = ~(a & b);
      3'b101:  r = ~(a ^ b);
      3'b110:  r = a & ~b;
      3'b111:  r = a;
      default: r = a;
    endcase
    return r;
  endfunction

  assign accept_s  = (state_r == IDLE) && in_valid;
  assign last_s    = (cnt_r == LAST_CHUNK);
  assign release_s = (state_r == DONE) && out_ready;

  // Current chunk result merged into the result register image.
  always_comb begin
    chunk_s    = bit_fn(op_r, x_r[cnt_r*CHUNK +: CHUNK], y_r[cnt_r*CHUNK +: CHUNK]);
    res_next_s = res_r;
    res_next_s[cnt_r*CHUNK +: CHUNK] = chunk_s;
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: accept, walk the chunks, wait for the consumer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_next_s = BUSY;
        else          state_next_s = IDLE;
      end
      BUSY: begin
        if (last_s) state_next_s = DONE;
        else        state_next_s = BUSY;
      end
      DONE: begin
        if (release_s) state_next_s = IDLE;
        else           state_next_s = DONE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state register.
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state_r)
      IDLE:    in_ready  = 1'b1;
      BUSY:    busy      = 1'b1;
      DONE:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // Operand latch, chunk counter, result and zero flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x_r    <= '0;
      y_r    <= '0;
      op_r   <= 3'b000;
      res_r  <= '0;
      cnt_r  <= '0;
      zero_r <= 1'b0;
    end else if (accept_s) begin
      x_r    <= x;
      y_r    <= y;
      op_r   <= op;
      res_r  <= '0;
      cnt_r  <= '0;
      zero_r <= 1'b0;
    end else if (state_r == BUSY) begin
      res_r <= res_next_s;
      if (last_s) begin
        cnt_r  <= '0;
        zero_r <= (res_next_s == '0);
      end else begin
        cnt_r  <= cnt_r + CW'(1);
        zero_r <= zero_r;
      end
    end else begin
      res_r  <= res_r;
      cnt_r  <= cnt_r;
      zero_r <= zero_r;
    end
  end

  assign res  = res_r;
  assign zero = zero_r;

`ifdef BLU_POPCOUNT_EN
  localparam int PW = $clog2(WIDTH + 1);

  logic [PW-1:0] popcnt_r;

  // Number of set bits in one chunk.
  function automatic logic [PW-1:0] chunk_ones(input logic [CHUNK-1:0] v);
    logic [PW-1:0] n;
    n = '0;
    for (int i = 0; i < CHUNK; i++) begin
      n = n + PW'(v[i]);
    end
    return n;
  endfunction

  // Running population count, one chunk per BUSY cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      popcnt_r <= '0;
    end else if (accept_s) begin
      popcnt_r <= '0;
    end else if (state_r == BUSY) begin
      popcnt_r <= popcnt_r + chunk_ones(chunk_s);
    end else begin
      popcnt_r <= popcnt_r;
    end
  end

  assign popcnt = popcnt_r;
`endif

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Self-checking bench for bitwise_logic_unit: a WIDTH=32/CHUNK=8 instance
// plus a CHUNK=32 single-cycle instance, checked against a full-width model.
module tb_bitwise_logic_unit;

  localparam int NCH = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  int          checks = 0;
  int          errors = 0;

  logic        in_valid = 1'b0, out_ready = 1'b1;
  logic [2:0]  op = 3'b000;
  logic [31:0] x = 32'h0, y = 32'h0;
  logic        in_ready, out_valid, zero, busy;
  logic [31:0] res;

  logic        in_valid1 = 1'b0, out_ready1 = 1'b1;
  logic [2:0]  op1 = 3'b000;
  logic [31:0] x1 = 32'h0, y1 = 32'h0;
  logic        in_ready1, out_valid1, zero1, busy1;
  logic [31:0] res1;
`ifdef BLU_POPCOUNT_EN
  logic [5:0]  popcnt, popcnt1;
`endif

  always #5 clock = ~clock;

  bitwise_logic_unit #(.WIDTH(32), .CHUNK(8)) u_dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .zero(zero), .busy(busy)
`ifdef BLU_POPCOUNT_EN
    , .popcnt(popcnt)
`endif
  );

  bitwise_logic_unit #(.WIDTH(32), .CHUNK(32)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .op(op1), .x(x1), .y(y1), .out_valid(out_valid1), .out_ready(out_ready1),
    .res(res1), .zero(zero1), .busy(busy1)
`ifdef BLU_POPCOUNT_EN
    , .popcnt(popcnt1)
`endif
  );

  // Full-width reference of the operation table.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    case (o)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a | b);
      3'd4:    return ~(a & b);
      3'd5:    return ~(a ^ b);
      3'd6:    return a & ~b;
      default: return a;
    endcase
  endfunction

  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string tag);
    int cyc;
    @(negedge clock);
    op = o; x = a; y = b; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clock);
    in_valid = 1'b0; op = 3'($urandom); x = $urandom; y = $urandom;
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s busy: busy=%b out_valid=%b required busy=1 out_valid=0", tag, busy, out_valid);
    end
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    checks++;
    if (out_valid !== 1'b1 || cyc != NCH) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles (out_valid=%b) required %0d", tag, cyc, out_valid, NCH);
    end
    checks++;
    if (res !== exp) begin
      errors++;
      $display("FAIL %s res: got %h required %h", tag, res, exp);
    end
    checks++;
    if (zero !== (exp == 32'h0)) begin
      errors++;
      $display("FAIL %s zero: got %b required %b", tag, zero, (exp == 32'h0));
    end
`ifdef BLU_POPCOUNT_EN
    checks++;
    if (popcnt !== 6'($countones(exp))) begin
      errors++;
      $display("FAIL %s popcnt: got %0d required %0d", tag, popcnt, $countones(exp));
    end
`endif
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s release: out_valid=%b in_ready=%b busy=%b required 0 1 0", tag, out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || res !== 32'h0 || zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b res=%h zero=%b required 1 0 0 0 0",
               in_ready, out_valid, busy, res, zero);
    end
  endtask

  task automatic test_reset_mid_busy();
    @(negedge clock);
    op = 3'd0; x = 32'hFFFFFFFF; y = 32'hFFFFFFFF; in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || res !== 32'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_busy: out_valid=%b res=%h busy=%b required 0 0 0", out_valid, res, busy);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
    end
    do_op(3'd0, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000, "after_reset");
  endtask

  task automatic test_op_sweep();
    logic [31:0] tbl [8];
    tbl[0] = 32'h0000A5A5; tbl[1] = 32'hA5A5FFFF; tbl[2] = 32'hA5A55A5A; tbl[3] = 32'h5A5A0000;
    tbl[4] = 32'hFFFF5A5A; tbl[5] = 32'h5A5AA5A5; tbl[6] = 32'hA5A50000; tbl[7] = 32'hA5A5A5A5;
    for (int i = 0; i < 8; i++) begin
      do_op(3'(i), 32'hA5A5A5A5, 32'h0000FFFF, tbl[i], $sformatf("sweep_op%0d", i));
    end
  endtask

  task automatic test_zero_flag();
    do_op(3'd2, 32'h12345678, 32'h12345678, 32'h0, "zero_set");
    do_op(3'd1, 32'h0, 32'h1, 32'h1, "zero_clear");
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      do_op(o, a, b, model(o, a, b), $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp;
    int cyc;
    exp = model(3'd5, 32'hDEADBEEF, 32'h0F0F00FF);
    @(negedge clock);
    op = 3'd5; x = 32'hDEADBEEF; y = 32'h0F0F00FF; in_valid = 1'b1; out_ready = 1'b0;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_done_timeout: out_valid=%b required 1", out_valid);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || res !== exp) begin
        errors++;
        $display("FAIL bp_hold%0d: in_ready=%b out_valid=%b res=%h required 0 1 %h", i, in_ready, out_valid, res, exp);
      end
      op = 3'($urandom); x = $urandom; y = $urandom; in_valid = 1'b1;
      @(negedge clock);
    end
    out_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b required 0 1 0", out_valid, in_ready, busy);
    end
    in_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_single: in_ready=%b busy=%b out_valid=%b required 1 0 0", in_ready, busy, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int          acc[$];
    logic        prev;
    logic [31:0] a, b, exp;
    int          seen;
    a = $urandom; b = $urandom; exp = model(3'd2, a, b);
    prev = 1'b0; seen = 0;
    @(negedge clock);
    op = 3'd2; x = a; y = b; in_valid = 1'b1; out_ready = 1'b1;
    for (int t = 0; t < 30; t++) begin
      @(negedge clock);
      if (busy === 1'b1 && prev !== 1'b1) acc.push_back(t);
      prev = busy;
      if (out_valid === 1'b1) begin
        seen++;
        checks++;
        if (res !== exp) begin
          errors++;
          $display("FAIL b2b_res: got %h required %h", res, exp);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (acc.size() < 3 || seen < 3) begin
      errors++;
      $display("FAIL b2b_count: accepts=%0d results=%0d required >=3", acc.size(), seen);
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (acc[i] - acc[i-1] != NCH + 2) begin
          errors++;
          $display("FAIL b2b_period: got %0d required %0d", acc[i] - acc[i-1], NCH + 2);
        end
      end
    end
    for (int i = 0; i < 20 && !(in_ready === 1'b1 && out_valid === 1'b0); i++) @(negedge clock);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_drain: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_single_cycle();
    logic [2:0]  o;
    logic [31:0] a, b, exp;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        o = 3'd3; a = 32'h0; b = 32'h0;
      end else begin
        o = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
      end
      exp = model(o, a, b);
      @(negedge clock);
      op1 = o; x1 = a; y1 = b; in_valid1 = 1'b1; out_ready1 = 1'b1;
      @(negedge clock);
      in_valid1 = 1'b0;
      checks++;
      if (busy1 !== 1'b1 || out_valid1 !== 1'b0) begin
        errors++;
        $display("FAIL single%0d_busy: busy=%b out_valid=%b required 1 0", i, busy1, out_valid1);
      end
      @(negedge clock);
      checks++;
      if (out_valid1 !== 1'b1 || res1 !== exp || zero1 !== (exp == 32'h0)) begin
        errors++;
        $display("FAIL single%0d: out_valid=%b res=%h zero=%b required 1 %h %b", i, out_valid1, res1, zero1, exp, (exp == 32'h0));
      end
`ifdef BLU_POPCOUNT_EN
      checks++;
      if (popcnt1 !== 6'($countones(exp))) begin
        errors++;
        $display("FAIL single%0d_popcnt: got %0d required %0d", i, popcnt1, $countones(exp));
      end
`endif
      @(negedge clock);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    do_op(3'd0, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000, "directed_and");
    test_op_sweep();
    test_zero_flag();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_busy();
    test_random();
    test_single_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
